led_matrix_scan: RTL and testbench

- Parametrised successor to the 8x8 reaction-game LED matrix driver.
- Row-scans a ROWS x COLS matrix and selects a pattern and RGB colour from the game state code.
- Patterns: host-loadable scrolling banner, concentric-ring "wait" animation, fixed faces and a "react now" square.
- Sits between the game FSM and the board matrix pins.

---
 rtl/led_matrix_scan.sv | 257 +++++++++++++++++++++++++
 tb/tb_led_matrix_scan.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Row-scanning driver for a ROWS x COLS LED matrix sitting between the
//   reaction-game FSM and the board pins. The game state code selects the
//   pattern and the RGB indicator colour:
//     000 host-loaded scrolling banner (RGB 111)
//     001 concentric-ring "wait" animation (RGB rotates 100->001->010)
//     010 sad face (RGB 100)
//     011 centred 4x4 "react now" square (RGB 010)
//     111 smile (RGB 001)
//     other codes blank the matrix and the indicator.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   state        game state code
//   ban_we       banner row write strobe (ban_row >= ROWS is ignored)
//   ban_row      banner row index
//   ban_data     banner row contents, MSB is the leftmost visible column
//   RGB          {R,Y,G} indicator, active-high, registered
//   row          one-hot row select, active-high, registered
//   col          column data for the selected row, bit COLS-1 leftmost
//   frame_done   one-cycle pulse when row wraps from ROWS-1 back to 0
//
// Optional feature (compile-time macro BLINK_EN)
//   When defined, the sad face blinks: col is forced to 0 during alternate
//   periods of 16*ANIM_DIV clocks, starting visible on entry to 010.
//   When undefined the sad face is steady and no blink logic exists.

module led_matrix_scan #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned SCAN_DIV   = 1,
  parameter int unsigned ANIM_DIV   = 32,
  parameter int unsigned SCROLL_DIV = 768,
  parameter int unsigned TEXT_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              state,
  input  logic                    ban_we,
  input  logic [$clog2(ROWS)-1:0] ban_row,
  input  logic [TEXT_W-1:0]       ban_data,
  output logic [2:0]              RGB,
  output logic [ROWS-1:0]         row,
  output logic [COLS-1:0]         col,
  output logic                    frame_done
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned MINRC = (ROWS < COLS) ? ROWS : COLS;
  localparam int unsigned K     = MINRC / 2;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned AW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned SRW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned ROFF  = (ROWS - 8) / 2;
  localparam int unsigned COFF  = (COLS - 8) / 2;
  localparam int unsigned FSH   = COLS - 8 - COFF;
  localparam int unsigned SQ_R0 = ROWS / 2 - 2;
  localparam int unsigned SQ_C0 = COLS / 2 - 2;

  typedef enum logic [2:0] {
    ST_BANNER = 3'b000,
    ST_RINGS  = 3'b001,
    ST_SAD    = 3'b010,
    ST_SQUARE = 3'b011,
    ST_SMILE  = 3'b111
  } code_t;

  logic [RW-1:0]     idx;
  logic [SCW-1:0]    scan_cnt;
  logic [AW-1:0]     anim_cnt;
  logic [SRW-1:0]    scroll_cnt;
  logic [KW-1:0]     ring;
  logic [2:0]        rotor;
  logic [2:0]        prev_state;
  logic [TEXT_W-1:0] banner [ROWS];

  logic              scan_step;
  logic              anim_step;
  logic              scroll_step;
  logic              rings_entry;
  logic [KW-1:0]     ring_eff;
  logic [2:0]        rotor_eff;
  logic [COLS-1:0]   col_next;
  logic [2:0]        rgb_next;

  function automatic logic [7:0] face_glyph(input logic smile, input logic [2:0] i);
    logic [7:0] g;
    case (i)
      3'd0:    g = 8'h3C;
      3'd1:    g = 8'h42;
      3'd2:    g = 8'hA5;
      3'd3:    g = 8'h81;
      3'd4:    g = smile ? 8'hA5 : 8'h99;
      3'd5:    g = smile ? 8'h99 : 8'hA5;
      3'd6:    g = 8'h42;
      default: g = 8'h3C;
    endcase
    return g;
  endfunction

  assign scan_step   = (scan_cnt == SCW'(SCAN_DIV - 1));
  assign anim_step   = (anim_cnt == AW'(ANIM_DIV - 1));
  assign scroll_step = (scroll_cnt == SRW'(SCROLL_DIV - 1));

  // On the first cycle in 001 the ring/rotor registers still hold stale
  // values; substitute the restart values so the first frame is the outer
  // ring in red without waiting a clock.
  assign rings_entry = (state == ST_RINGS) && (prev_state != ST_RINGS);
  assign ring_eff    = rings_entry ? '0 : ring;
  assign rotor_eff   = rings_entry ? 3'b100 : rotor;

`ifdef BLINK_EN
  localparam int unsigned BLINK_DIV = 16 * ANIM_DIV;
  localparam int unsigned BW        = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic          sad_entry;
  logic          blank_eff;

  assign sad_entry = (state == ST_SAD) && (prev_state != ST_SAD);
  assign blank_eff = sad_entry ? 1'b0 : blink_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (sad_entry) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`endif

  // Pattern generation for the row currently addressed by idx.
  always_comb begin
    int unsigned r;
    int unsigned dr;
    int unsigned dc;
    int unsigned d;
    int unsigned fr;
    logic [COLS-1:0] glyph;
    col_next = '0;
    rgb_next = '0;
    glyph    = '0;
    dc       = 0;
    d        = 0;
    r        = 32'(idx);
    dr       = (r < ROWS - 1 - r) ? r : ROWS - 1 - r;
    // Rows above the face wrap to a huge value and fail the < 8 test.
    fr       = r - ROFF;
    case (state)
      ST_BANNER: begin
        col_next = banner[idx][TEXT_W-1 -: COLS];
        rgb_next = 3'b111;
      end
      ST_RINGS: begin
        for (int unsigned c = 0; c < COLS; c++) begin
          dc = (c < COLS - 1 - c) ? c : COLS - 1 - c;
          d  = (dr < dc) ? dr : dc;
          col_next[c] = (d == 32'(ring_eff));
        end
        rgb_next = rotor_eff;
      end
      ST_SAD: begin
        if (fr < 8) glyph[7:0] = face_glyph(1'b0, fr[2:0]);
        col_next = glyph << FSH;
`ifdef BLINK_EN
        if (blank_eff) col_next = '0;
`endif
        rgb_next = 3'b100;
      end
      ST_SQUARE: begin
        if (r >= SQ_R0 && r <= SQ_R0 + 3) col_next[SQ_C0 +: 4] = '1;
        rgb_next = 3'b010;
      end
      ST_SMILE: begin
        if (fr < 8) glyph[7:0] = face_glyph(1'b1, fr[2:0]);
        col_next = glyph << FSH;
        rgb_next = 3'b001;
      end
      default: begin
        col_next = '0;
        rgb_next = '0;
      end
    endcase
  end

  // Scan index, outputs and frame marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      scan_cnt   <= '0;
      row        <= '0;
      col        <= '0;
      RGB        <= '0;
      frame_done <= 1'b0;
      prev_state <= '0;
    end else begin
      prev_state <= state;
      row        <= ROWS'(1) << idx;
      col        <= col_next;
      RGB        <= rgb_next;
      // row still shows the last row while idx has already wrapped to 0.
      frame_done <= row[ROWS-1] && (idx == '0);
      if (scan_step) begin
        scan_cnt <= '0;
        idx      <= (idx == RW'(ROWS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Ring animation and RGB rotor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_cnt <= '0;
      ring     <= '0;
      rotor    <= 3'b100;
    end else if (rings_entry) begin
      anim_cnt <= '0;
      ring     <= '0;
      rotor    <= 3'b100;
    end else if (anim_step) begin
      anim_cnt <= '0;
      ring     <= (ring == KW'(K - 1)) ? '0 : ring + 1'b1;
      rotor    <= {rotor[1:0], rotor[2]};
    end else begin
      anim_cnt <= anim_cnt + 1'b1;
    end
  end

  // Banner store: all rows rotate left together; a host write to a row
  // takes priority over that row's rotation in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_cnt <= '0;
      for (int unsigned i = 0; i < ROWS; i++) banner[i] <= '0;
    end else begin
      scroll_cnt <= scroll_step ? '0 : scroll_cnt + 1'b1;
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (ban_we && (32'(ban_row) == i))
          banner[i] <= ban_data;
        else if (scroll_step)
          banner[i] <= {banner[i][TEXT_W-2:0], banner[i][TEXT_W-1]};
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
module tb_led_matrix_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  state;
  logic        ban_we;
  logic [2:0]  ban_row;
  logic [11:0] ban_data;

  logic [2:0]  rgb_s;
  logic [7:0]  row_s;
  logic [7:0]  col_s;
  logic        fd_s;

  logic [2:0]  big_state;
  logic [3:0]  big_ban_row;
  logic [11:0] big_ban_data;
  logic        big_ban_we;
  logic [2:0]  rgb_b;
  logic [9:0]  row_b;
  logic [9:0]  col_b;
  logic        fd_b;

  int cyc;
  int passed = 0;
  int total  = 0;

  typedef struct {
    int          cyc;
    bit          big;
    string       name;
    logic [15:0] row;
    logic [15:0] col;
    logic [2:0]  rgb;
    logic        fd;
  } exp_t;

  exp_t q[$];

  localparam logic [7:0]  SAD   [8] = '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'h99, 8'hA5, 8'h42, 8'h3C};
  localparam logic [7:0]  SMILE [8] = '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C};
  localparam logic [7:0]  RING0 [8] = '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
  localparam logic [7:0]  RING1 [8] = '{8'h00, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h42, 8'h7E, 8'h00};
  localparam logic [7:0]  SQ    [8] = '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00};
  localparam logic [15:0] BIGSM [10] = '{16'h000, 16'h078, 16'h084, 16'h14A, 16'h102,
                                         16'h14A, 16'h132, 16'h084, 16'h078, 16'h000};

  led_matrix_scan u_dut (
    .clk(clk), .rst_n(rst_n), .state(state), .ban_we(ban_we), .ban_row(ban_row),
    .ban_data(ban_data), .RGB(rgb_s), .row(row_s), .col(col_s), .frame_done(fd_s)
  );

  led_matrix_scan #(.ROWS(10), .COLS(10)) u_big (
    .clk(clk), .rst_n(rst_n), .state(big_state), .ban_we(big_ban_we), .ban_row(big_ban_row),
    .ban_data(big_ban_data), .RGB(rgb_b), .row(row_b), .col(col_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input int n, input bit big, input string nm, input logic [15:0] r,
                      input logic [15:0] c, input logic [2:0] g, input logic f);
    exp_t e;
    e.cyc = n; e.big = big; e.name = nm; e.row = r; e.col = c; e.rgb = g; e.fd = f;
    q.push_back(e);
  endtask

  // Expectation for the 8x8 unit at sample n (n-th edge after reset release).
  task automatic push_s(input int n, input string nm, input logic [7:0] c, input logic [2:0] g);
    push(n, 1'b0, nm, 16'(1) << ((n - 1) % 8), {8'h00, c}, g, (n >= 9) && ((n - 1) % 8 == 0));
  endtask

  task automatic push_b(input int n, input string nm);
    push(n, 1'b1, nm, 16'(1) << ((n - 1) % 10), BIGSM[(n - 1) % 10], 3'b001,
         (n >= 11) && ((n - 1) % 10 == 0));
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compares the DUT against queued expectations on the falling edge.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [15:0] ar;
    logic [15:0] ac;
    logic [2:0]  ag;
    logic        af;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e  = q.pop_front();
        ar = e.big ? {6'b0, row_b} : {8'b0, row_s};
        ac = e.big ? {6'b0, col_b} : {8'b0, col_s};
        ag = e.big ? rgb_b : rgb_s;
        af = e.big ? fd_b : fd_s;
        total++;
        if (e.cyc != cyc)
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
        else if ({ar, ac, ag, af} !== {e.row, e.col, e.rgb, e.fd})
          $display("FAIL %s cyc %0d: got row=%h col=%h rgb=%b fd=%b, want row=%h col=%h rgb=%b fd=%b",
                   e.name, cyc, ar, ac, ag, af, e.row, e.col, e.rgb, e.fd);
        else
          passed++;
      end
    end
  end

  initial begin
    state = 3'b010; ban_we = 1'b0; ban_row = '0; ban_data = '0;
    big_state = 3'b111; big_ban_we = 1'b0; big_ban_row = '0; big_ban_data = '0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    ban_we = 1'b1; ban_row = 3'd0; ban_data = 12'hFC0;
    for (int n = 1; n <= 16; n++) begin
      push_s(n, "sad", SAD[(n - 1) % 8], 3'b100);
      if (n <= 11) push_b(n, "big_smile");
    end
    at(1);
    ban_we = 1'b0;

    at(20);
    state = 3'b001;
    for (int n = 21; n <= 28; n++) push_s(n, "ring0", RING0[(n - 1) % 8], 3'b100);
    push_s(53, "ring0_last", RING0[4], 3'b100);
    for (int n = 54; n <= 61; n++) push_s(n, "ring1", RING1[(n - 1) % 8], 3'b001);

    at(70);
    state = 3'b011;
    for (int n = 71; n <= 78; n++) push_s(n, "square", SQ[(n - 1) % 8], 3'b010);

    at(80);
    state = 3'b001;
    for (int n = 81; n <= 88; n++) push_s(n, "ring_reentry", RING0[(n - 1) % 8], 3'b100);

    at(90);
    state = 3'b100;
    push_s(91, "undef_code", 8'h00, 3'b000);
    push_s(92, "undef_code", 8'h00, 3'b000);

    at(95);
    state = 3'b111;
    for (int n = 96; n <= 103; n++) push_s(n, "smile", SMILE[(n - 1) % 8], 3'b001);

    at(110);
    state = 3'b000;
    for (int n = 111; n <= 118; n++)
      push_s(n, "banner", ((n - 1) % 8 == 0) ? 8'hFC : 8'h00, 3'b111);
    push_s(761, "banner_pre_scroll", 8'hFC, 3'b111);
    push_s(769, "banner_scroll1", 8'hF8, 3'b111);

    at(1535);
    ban_we = 1'b1; ban_row = 3'd1; ban_data = 12'hABC;
    push_s(1537, "banner_scroll2_row0", 8'hF0, 3'b111);
    push_s(1538, "banner_write_wins", 8'hAB, 3'b111);
    at(1536);
    ban_we = 1'b0;
    push_s(9209, "banner_scroll11", 8'h7E, 3'b111);
    push_s(9217, "banner_wrap", 8'hFC, 3'b111);

    at(9220);
    state = 3'b010;
    push_s(9700, "sad_visible", SAD[3], 3'b100);
`ifdef BLINK_EN
    push_s(9800, "sad_blink", 8'h00, 3'b100);
`else
    push_s(9800, "sad_steady", SAD[7], 3'b100);
`endif

    at(9802);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({row_s, col_s, rgb_s, fd_s} !== '0)
      $display("FAIL reset_small: got row=%h col=%h rgb=%b fd=%b, want all 0", row_s, col_s, rgb_s, fd_s);
    else
      passed++;
    total++;
    if ({row_b, col_b, rgb_b, fd_b} !== '0)
      $display("FAIL reset_big: got row=%h col=%h rgb=%b fd=%b, want all 0", row_b, col_b, rgb_b, fd_b);
    else
      passed++;

    @(negedge clk);
    rst_n = 1'b1;
    push_s(1, "post_reset", SAD[0], 3'b100);
    push_b(1, "post_reset_big");
    push_s(2, "post_reset", SAD[1], 3'b100);
    push_b(2, "post_reset_big");
    at(4);

    total++;
    if (q.size() != 0)
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
